// File: rtl/uram_arbiter.sv
// Round-robin arbiter sharing one single-port UltraRAM between two requesters.
// Each port gets at most MAX_BURST consecutive grants while the other waits; reads return one cycle later.
module uram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int            CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic          grant0, grant1;
    logic          owner_keeps;

    // Handshake: port N fires when reqN_valid && reqN_ready; ready is only ever
    // raised for a valid port, never during reset, and for at most one port.
    always_comb begin
        owner_keeps = (cnt_q < MAX_C);
        grant0      = 1'b0;
        grant1      = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = owner_keeps ? ~owner_q : owner_q;
                grant1 = ~grant0;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (grant0 || grant1) begin
            if (grant1 == owner_q) begin
                if (cnt_q != MAX_C) begin
                    cnt_d = cnt_q + ONE_C;
                end
            end else begin
                owner_d = grant1;
                cnt_d   = ONE_C;
            end
        end
        rsp0_valid_d = grant0 && !req0_we;
        rsp1_valid_d = grant1 && !req1_we;
    end

    // Memory port is zeroed when nothing fires so idle cycles are clean on the bus.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (grant0) begin
            mem_wr_en = req0_we;
            mem_addr  = req0_addr;
            mem_din   = req0_wdata;
        end else if (grant1) begin
            mem_wr_en = req1_we;
            mem_addr  = req1_addr;
            mem_din   = req1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = mem_dout;
    assign rsp1_rdata = mem_dout;

endmodule

// File: tb/tb_uram_arbiter.sv
// Directed bench for uram_arbiter: DUT a uses MAX_BURST=4, DUT b uses MAX_BURST=1,
// both driven by the same request inputs and each backed by its own read-first memory model.
module tb_uram_arbiter;

    localparam int DW = 32;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;

    logic          a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_mem_wr_en;
    logic [DW-1:0] a_rsp0_rdata, a_rsp1_rdata, a_mem_din, a_mem_dout;
    logic [AW-1:0] a_mem_addr;
    logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_mem_wr_en;
    logic [DW-1:0] b_rsp0_rdata, b_rsp1_rdata, b_mem_din, b_mem_dout;
    logic [AW-1:0] b_mem_addr;

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata),
        .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata),
        .mem_wr_en(a_mem_wr_en), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
        .mem_dout(a_mem_dout)
    );

    uram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
        .mem_dout(b_mem_dout)
    );

    // Single-port RAM models: one-cycle registered read, read-first.
    always @(posedge clk) begin
        if (a_mem_wr_en) mem_a[a_mem_addr] <= a_mem_din;
        a_mem_dout <= mem_a[a_mem_addr];
        if (b_mem_wr_en) mem_b[b_mem_addr] <= b_mem_din;
        b_mem_dout <= mem_b[b_mem_addr];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic drive0(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    endtask

    task automatic drive1(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic exp_g1;
        logic prev_g1;

        for (int i = 0; i < (1 << AW); i++) begin
            mem_a[i] = 32'hA000_0000 + i;
            mem_b[i] = 32'hA000_0000 + i;
        end
        rst = 1'b1;
        idle_inputs();
        a_mem_dout = '0;
        b_mem_dout = '0;

        // Reset state: requests present but nothing may be accepted.
        repeat (2) @(negedge clk);
        drive0(1'b1, 14'd7, 32'h1111_1111);
        drive1(1'b1, 14'd8, 32'h2222_2222);
        #1;
        check("rst_ready0", a_req0_ready, 0);
        check("rst_ready1", a_req1_ready, 0);
        check("rst_wr_en", a_mem_wr_en, 0);
        check("rst_rsp0", a_rsp0_valid, 0);
        check("rst_rsp1", a_rsp1_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("idle_addr", a_mem_addr, 0);

        // Write then read on port 0.
        @(negedge clk);
        drive0(1'b1, 14'd5, 32'hDEAD_BEEF);
        #1;
        check("wr_ready0", a_req0_ready, 1);
        check("wr_wr_en", a_mem_wr_en, 1);
        check("wr_addr", a_mem_addr, 5);
        check("wr_din", a_mem_din, 32'hDEAD_BEEF);
        @(negedge clk);
        drive0(1'b0, 14'd5, 32'h0);
        #1;
        check("rd_ready0", a_req0_ready, 1);
        check("rd_wr_en", a_mem_wr_en, 0);
        check("wr_no_rsp", a_rsp0_valid, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rd_rsp0_valid", a_rsp0_valid, 1);
        check("rd_rsp0_data", a_rsp0_rdata, 32'hDEAD_BEEF);
        check("rd_rsp1_valid", a_rsp1_valid, 0);
        @(negedge clk);
        #1;
        check("rd_rsp0_once", a_rsp0_valid, 0);

        // Cross-port coherence at the top address.
        @(negedge clk);
        drive1(1'b1, 14'h3FFF, 32'h0000_1234);
        #1;
        check("xp_ready1", a_req1_ready, 1);
        check("xp_addr", a_mem_addr, 32'h3FFF);
        @(negedge clk);
        idle_inputs();
        drive0(1'b0, 14'h3FFF, 32'h0);
        #1;
        check("xp_ready0", a_req0_ready, 1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("xp_rsp0_valid", a_rsp0_valid, 1);
        check("xp_rsp0_data", a_rsp0_rdata, 32'h0000_1234);
        check("xp_rsp1_valid", a_rsp1_valid, 0);

        // Sustained contention from reset: a bursts 4/4, b alternates.
        apply_reset();
        drive0(1'b0, 14'h10, 32'h0);
        drive1(1'b0, 14'h20, 32'h0);
        prev_g1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_g1 = ((i / 4) % 2) == 1;
            check($sformatf("burst_r0_%0d", i), a_req0_ready, !exp_g1);
            check($sformatf("burst_r1_%0d", i), a_req1_ready, exp_g1);
            check($sformatf("alt_r0_%0d", i), b_req0_ready, (i % 2) == 0);
            check($sformatf("alt_r1_%0d", i), b_req1_ready, (i % 2) == 1);
            if (i > 0) begin
                check($sformatf("burst_rsp0_%0d", i), a_rsp0_valid, !prev_g1);
                check($sformatf("burst_rsp1_%0d", i), a_rsp1_valid, prev_g1);
                check($sformatf("burst_data_%0d", i), a_rsp0_rdata,
                      prev_g1 ? 32'hA000_0020 : 32'hA000_0010);
            end
            prev_g1 = exp_g1;
            @(negedge clk);
        end

        // Port 1 alone for 10 beats, then port 0 joins and wins at once.
        idle_inputs();
        drive1(1'b0, 14'h21, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("solo_r1_%0d", i), a_req1_ready, 1);
            @(negedge clk);
        end
        drive0(1'b0, 14'h11, 32'h0);
        #1;
        check("join_r0", a_req0_ready, 1);
        check("join_r1", a_req1_ready, 0);

        // Reset arriving right after a port 0 read fires.
        @(negedge clk);
        idle_inputs();
        drive0(1'b0, 14'h12, 32'h0);
        #1;
        check("mid_fire0", a_req0_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        drive0(1'b1, 14'h12, 32'h5555_5555);
        drive1(1'b1, 14'h13, 32'h6666_6666);
        #1;
        check("mid_rsp_pre", a_rsp0_valid, 1);
        check("mid_ready0", a_req0_ready, 0);
        check("mid_ready1", a_req1_ready, 0);
        check("mid_wr_en", a_mem_wr_en, 0);
        @(negedge clk);
        #1;
        check("mid_rsp_drop", a_rsp0_valid, 0);
        check("mid_wr_en2", a_mem_wr_en, 0);
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b0, 14'h12, 32'h0);
        drive1(1'b0, 14'h13, 32'h0);
        #1;
        check("post_rst_r0", a_req0_ready, 1);
        check("post_rst_r1", a_req1_ready, 0);
        check("post_rst_b_r0", b_req0_ready, 1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post_rst_rsp0", a_rsp0_valid, 1);
        check("post_rst_data", a_rsp0_rdata, 32'hA000_0012);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uram_arbiter.md
# uram_arbiter

Two-port arbiter that shares one single-port UltraRAM (`sp_uram`, 1-cycle registered read) between two requesters. Each requester issues read/write beats over a valid/ready handshake. Arbitration is round-robin with a configurable burst allowance. Read data returns to the issuing requester exactly one cycle after its beat is accepted. The block sits directly in front of `sp_uram` and drives all of its ports.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: word width; must match the attached `sp_uram`.
- `ADDR_WIDTH`, default 14: word address width; must match `sp_uram`.
- `MAX_BURST`, default 4: maximum consecutive grants to one port while the other port waits; ≥1. A value of 1 gives pure alternation.

**Ports**
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req0_valid`, `req1_valid` in 1: beat request from port N.
- `req0_ready`, `req1_ready` out 1: beat accepted this cycle; combinational.
- `req0_we`, `req1_we` in 1: 1 = write, 0 = read.
- `req0_addr`, `req1_addr` in ADDR_WIDTH: word address.
- `req0_wdata`, `req1_wdata` in DATA_WIDTH: write data.
- `rsp0_valid`, `rsp1_valid` out 1: read data valid for port N; registered, no backpressure.
- `rsp0_rdata`, `rsp1_rdata` out DATA_WIDTH: read data; equals `mem_dout`.
- `mem_wr_en` out 1: drives `sp_uram.wr_en`.
- `mem_addr` out ADDR_WIDTH: drives `sp_uram.addr`.
- `mem_din` out DATA_WIDTH: drives `sp_uram.din`.
- `mem_dout` in DATA_WIDTH: from `sp_uram.dout`.

## Operation

**Beat acceptance**
- Port N fires when `reqN_valid && reqN_ready`.
- At most one port fires per cycle.
- `reqN_ready` never asserts unless `reqN_valid` is high.

**Arbitration state**
- `owner`: the last granted port.
- `cnt`: consecutive grants to `owner`; width clog2(MAX_BURST+1); saturates at MAX_BURST.

**Grant rules**
- Only one port valid: grant that port.
- Both ports valid: grant `owner` if `cnt < MAX_BURST`, else grant the other port.
- Neither port valid: no grant; `owner` and `cnt` are unchanged.

**State update on a grant**
- Granted port equals `owner`: `cnt <= min(cnt+1, MAX_BURST)`.
- Granted port differs from `owner`: `owner <=` granted port, `cnt <= 1`.
- Idle cycles do not reset `cnt`.

**Memory drive**
- On a fire: `mem_addr` = granted `reqN_addr`, `mem_din` = granted `reqN_wdata`, `mem_wr_en` = granted `reqN_we`.
- No fire: `mem_wr_en` = 0, `mem_addr` = 0, `mem_din` = 0.

**Responses**
- Read fire on port N at edge E: `rspN_valid` = 1 for exactly the cycle after E.
- `rspN_rdata` = `mem_dout` during that cycle.
- Write fires produce no response.
- Both `rspN_rdata` outputs always mirror `mem_dout`; consumers qualify with `rspN_valid`.

**Read-during-write semantics**
- A read of an address written in an earlier cycle returns the new data.
- The memory is read-first. Because reads and writes never share a cycle, no same-cycle hazard exists.

**Reset**
- `owner` = 0, `cnt` = 0, so port 0 wins the first contention.
- `rsp0_valid` = `rsp1_valid` = 0.
- A read accepted in the cycle `rst` is sampled high produces no response; the in-flight response is dropped.
- While `rst` is high: `req0_ready` = `req1_ready` = 0 and `mem_wr_en` = 0.

## Timing

- Arbitration, ready, and memory drive are combinational from `req*` inputs plus registered `owner`/`cnt`. Path length is one mux level plus compare.
- Read latency: 1 cycle from fire edge to `rspN_valid`.
- Throughput: 1 beat per cycle aggregate.
- Worst-case wait for a continuously valid port: MAX_BURST cycles.
- Back-to-back reads on alternating ports produce alternating `rsp0_valid`/`rsp1_valid` on consecutive cycles.

## Test plan

- **Write then read, single port:** reset; port 0 writes 0xDEADBEEF to addr 5, then reads addr 5. Required: `req0_ready` = 1 both cycles, `rsp0_valid` = 1 one cycle after the read with `rsp0_rdata` = 0xDEADBEEF, `rsp1_valid` = 0 throughout.
- **Sustained contention, MAX_BURST=4:** both ports hold valid reads from reset. Required: grant sequence 0,0,0,0,1,1,1,1,0,0,…; responses follow the same pattern one cycle later.
- **Pure alternation, MAX_BURST=1:** both ports hold valid. Required: grants strictly alternate 0,1,0,1,…
- **Single requester, no starvation penalty:** only port 1 valid for 10 cycles with MAX_BURST=4. Required: all 10 beats accepted consecutively. Then port 0 also asserts valid. Required: port 0 is granted on the very next cycle, because `cnt` is saturated at 4.
- **Cross-port coherence:** port 1 writes 0x1234 to addr 0x3FFF (max address) while port 0 waits. Then port 0 reads 0x3FFF. Required: `rsp0_rdata` = 0x1234.
- **Reset mid-operation:** assert `rst` in the cycle a port 0 read fires. Required: `rsp0_valid` = 0 next cycle, `mem_wr_en` = 0 and both readies 0 during reset, and the first contention after reset is won by port 0.
